// File: rtl/lenet_pkg.sv
// -----------------------------------------------------------------------------
// lenet_pkg
//   Constants and types shared by the LeNet conv datapath blocks
//   (conv_window_gen, calculate_2d).
//   - LENET_DATA_WIDTH : default pixel width (signed, matches the MAC tree)
//   - LENET_KERNEL     : default window edge
//   - LENET_CALC_LATENCY : MAC tree latency (mult_cell 1 + adder stages 5)
//   - state_t          : one-hot frame-control states
// -----------------------------------------------------------------------------
package lenet_pkg;

    localparam int LENET_DATA_WIDTH   = 16;
    localparam int LENET_KERNEL       = 5;
    localparam int LENET_CALC_LATENCY = 6;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_RUN   = 4'b0010,
        ST_FLUSH = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// -----------------------------------------------------------------------------
// conv_window_gen_if
//   Pixel-in / window-out bundle of the sliding-window generator.
//   master : upstream source (drives start, in_valid, pixel_in; observes the rest)
//   slave  : conv_window_gen
//   Signals:
//     start        1-cycle frame start pulse
//     in_valid     pixel_in valid
//     pixel_in     signed pixel, raster order
//     in_ready     generator accepts pixels
//     window_flat  KERNEL*KERNEL taps, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//     window_valid taps form a complete window
//     out_row/col  output coordinate of the window
//     res_valid    window_valid delayed by the MAC tree latency
//     res_last     res_valid of the final window of the frame
//     frame_done   1-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
interface conv_window_gen_if
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = LENET_DATA_WIDTH,
    parameter int KERNEL     = LENET_KERNEL,
    parameter int IN_WIDTH   = 32,
    parameter int IN_HEIGHT  = 32
);
    localparam int ROW_W = $clog2(IN_HEIGHT);
    localparam int COL_W = $clog2(IN_WIDTH);

    logic                                 start;
    logic                                 in_valid;
    logic signed [DATA_WIDTH-1:0]         pixel_in;
    logic                                 in_ready;
    logic [KERNEL*KERNEL*DATA_WIDTH-1:0]  window_flat;
    logic                                 window_valid;
    logic [ROW_W-1:0]                     out_row;
    logic [COL_W-1:0]                     out_col;
    logic                                 res_valid;
    logic                                 res_last;
    logic                                 frame_done;

    modport master (
        output start, in_valid, pixel_in,
        input  in_ready, window_flat, window_valid, out_row, out_col,
               res_valid, res_last, frame_done
    );

    modport slave (
        input  start, in_valid, pixel_in,
        output in_ready, window_flat, window_valid, out_row, out_col,
               res_valid, res_last, frame_done
    );

endinterface

// File: rtl/conv_window_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
//   One feature-map row of storage, addressed by the current column.
//   Read is combinational from the addressed slot, write lands on the clock
//   edge, so an accept reads the pixel one row above before overwriting it.
//   Ports:
//     clk      clock
//     we       write enable (pixel accepted)
//     addr     column index shared by the whole cascade
//     wr_data  pixel entering this row slot
//     rd_data  pixel stored one row earlier at this column
// -----------------------------------------------------------------------------
module line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // NOTE: storage arrays carry no reset so they map onto RAM/plain flops;
    // windows are only flagged valid once every tap holds current-frame data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//   Streaming KxK sliding-window generator for the conv MAC tree.
//   Raster-order pixels go through KERNEL-1 cascaded line buffers and a KxK
//   shift window; every complete window is presented with its coordinate and
//   a valid, and the valid is replayed CALC_LATENCY cycles later as res_valid.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    conv_window_gen_if.slave (stream in, window/result flags out)
// -----------------------------------------------------------------------------
module conv_window_gen
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH   = LENET_DATA_WIDTH,
    parameter int KERNEL       = LENET_KERNEL,
    parameter int IN_WIDTH     = 32,
    parameter int IN_HEIGHT    = 32,
    parameter int CALC_LATENCY = LENET_CALC_LATENCY
) (
    input logic              clk,
    input logic              rst_n,
    conv_window_gen_if.slave bus
);

    localparam int ROW_W   = $clog2(IN_HEIGHT);
    localparam int COL_W   = $clog2(IN_WIDTH);
    localparam int FLUSH_W = $clog2(CALC_LATENCY + 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic [FLUSH_W-1:0] flush_q;

    logic accept;
    logic last_col;
    logic last_pixel;
    logic at_window;

    assign accept     = bus.in_valid && bus.in_ready;
    assign last_col   = (col_q == COL_W'(IN_WIDTH - 1));
    assign last_pixel = last_col && (row_q == ROW_W'(IN_HEIGHT - 1));
    // Only windows whose leftmost column and top row are inside the frame;
    // this also keeps any window from straddling a row wrap.
    assign at_window  = (row_q >= ROW_W'(KERNEL - 1)) && (col_q >= COL_W'(KERNEL - 1));

    // ------------------------------------------------------------------ FSM
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first; a path that
    // leaves it unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start)                           state_d = ST_RUN;
            ST_RUN:   if (accept && last_pixel)                state_d = ST_FLUSH;
            ST_FLUSH: if (flush_q == FLUSH_W'(CALC_LATENCY))   state_d = ST_DONE;
            ST_DONE:                                           state_d = ST_IDLE;
            default:                                           state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state_q == ST_RUN);
        bus.frame_done = (state_q == ST_DONE);
    end

    // Holds FLUSH until the last window's result has left the MAC tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_q <= '0;
        end else if (state_q == ST_FLUSH) begin
            flush_q <= flush_q + FLUSH_W'(1);
        end else begin
            flush_q <= '0;
        end
    end

    // ------------------------------------------------------------- counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (state_q == ST_IDLE && bus.start) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                row_q <= last_pixel ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // --------------------------------------------------------- line buffers
    // lb_rd[k] is the pixel k+1 rows above the incoming one, same column.
    logic [DATA_WIDTH-1:0] lb_wr  [KERNEL-1];
    logic [DATA_WIDTH-1:0] lb_rd  [KERNEL-1];
    logic [DATA_WIDTH-1:0] col_in [KERNEL];

    assign lb_wr[0] = bus.pixel_in;

    for (genvar k = 1; k < KERNEL - 1; k++) begin : g_lb_link
        assign lb_wr[k] = lb_rd[k-1];
    end

    for (genvar k = 0; k < KERNEL - 1; k++) begin : g_lb
        line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IN_WIDTH)
        ) u_line_buffer (
            .clk     (clk),
            .we      (accept),
            .addr    (col_q),
            .wr_data (lb_wr[k]),
            .rd_data (lb_rd[k])
        );
    end

    // New right-hand column: oldest row at index 0, incoming pixel at the bottom.
    assign col_in[KERNEL-1] = bus.pixel_in;

    for (genvar i = 0; i < KERNEL - 1; i++) begin : g_col_in
        assign col_in[i] = lb_rd[KERNEL-2-i];
    end

    // ------------------------------------------------------- window shifter
    logic [DATA_WIDTH-1:0] win [KERNEL][KERNEL];

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < KERNEL; i++) begin
                for (int j = 0; j < KERNEL - 1; j++) begin
                    win[i][j] <= win[i][j+1];
                end
                win[i][KERNEL-1] <= col_in[i];
            end
        end
    end

    for (genvar i = 0; i < KERNEL; i++) begin : g_flat_row
        for (genvar j = 0; j < KERNEL; j++) begin : g_flat_col
            assign bus.window_flat[(i*KERNEL+j)*DATA_WIDTH +: DATA_WIDTH] = win[i][j];
        end
    end

    // ---------------------------------------------- window valid and coords
    logic             wv_q;
    logic             wlast_q;
    logic [ROW_W-1:0] out_row_q;
    logic [COL_W-1:0] out_col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wv_q      <= 1'b0;
            wlast_q   <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            wv_q    <= accept && at_window;
            wlast_q <= accept && at_window && last_pixel;
            if (accept && at_window) begin
                out_row_q <= row_q - ROW_W'(KERNEL - 1);
                out_col_q <= col_q - COL_W'(KERNEL - 1);
            end else begin
                out_row_q <= '0;
                out_col_q <= '0;
            end
        end
    end

    assign bus.window_valid = wv_q;
    assign bus.out_row      = out_row_q;
    assign bus.out_col      = out_col_q;

    // ------------------------------------------- MAC-tree latency delay line
    logic [CALC_LATENCY-1:0] res_v_sr;
    logic [CALC_LATENCY-1:0] res_l_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_v_sr <= '0;
            res_l_sr <= '0;
        end else begin
            res_v_sr <= (res_v_sr << 1) | CALC_LATENCY'(wv_q);
            res_l_sr <= (res_l_sr << 1) | CALC_LATENCY'(wlast_q);
        end
    end

    assign bus.res_valid = res_v_sr[CALC_LATENCY-1];
    assign bus.res_last  = res_l_sr[CALC_LATENCY-1];

endmodule
